// File: rtl/multi_test_runner_pkg.sv
// -----------------------------------------------------------------------------
// multi_test_runner_pkg
// Shared types and constants for the multi-test sequencer.
//   state_e : sequencer FSM states
//   IDX_W   : width of the test index (supports up to 32 test channels)
// -----------------------------------------------------------------------------
package multi_test_runner_pkg;

  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/multi_test_runner_timer.sv
// -----------------------------------------------------------------------------
// test_slot_timer
// Per-test cycle counter with the comparators that pace one test slot.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clr_i        : clear the counter (sequencer in PREP)
//   inc_i        : count this cycle (sequencer in RUN); saturates at all ones
//   rst_win_o    : NEXT counter value lies in [RST_START, RST_END]; lets the
//                  registered DUT reset line up with the counter itself
//   req_en_o     : counter > REQ_DELAY
//   chk_en_o     : counter > REQ_DELAY + SETTLE
//   tmo_o        : counter > TIMEOUT
// -----------------------------------------------------------------------------
module test_slot_timer #(
  parameter int CNT_W     = 32,
  parameter int RST_START = 3,
  parameter int RST_END   = 8,
  parameter int REQ_DELAY = 100,
  parameter int SETTLE    = 5,
  parameter int TIMEOUT   = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic rst_win_o,
  output logic req_en_o,
  output logic chk_en_o,
  output logic tmo_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next counter value: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rst_win_o = (cnt_d >= CNT_W'(RST_START)) && (cnt_d <= CNT_W'(RST_END));
  assign req_en_o  = (cnt_q > CNT_W'(REQ_DELAY));
  assign chk_en_o  = (cnt_q > CNT_W'(REQ_DELAY + SETTLE));
  assign tmo_o     = (cnt_q > CNT_W'(TIMEOUT));

endmodule

// File: rtl/multi_test_runner.sv
// -----------------------------------------------------------------------------
// multi_test_runner
// Sequences NUM_TESTS Synthesijer test methods (req/busy/return handshake):
// per test it pulses dut_reset, raises the request, waits for completion or
// timeout and records pass/fail.
// Optional build macro: STOP_ON_FAIL_EN -- end the run after the first failing
// test (cur_idx holds the failing index, untested result bits stay 0).
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : pulse, starts a run when idle (ignored otherwise)
//   dut_reset   : registered reset to the DUTs
//   test_req    : one-hot request to the current test
//   test_busy   : busy flags from the DUTs
//   test_return : return values from the DUTs (1 = pass)
//   cur_idx     : index of the running test
//   running     : high from start until done
//   done        : one-cycle pulse at end of run
//   pass        : all executed tests passed (valid with done)
//   pass_vec    : per-test pass bits
//   timeout_vec : per-test timeout bits
// -----------------------------------------------------------------------------
module multi_test_runner
  import multi_test_runner_pkg::*;
#(
  parameter int NUM_TESTS = 4,
  parameter int CNT_W     = 32,
  parameter int RST_START = 3,
  parameter int RST_END   = 8,
  parameter int REQ_DELAY = 100,
  parameter int SETTLE    = 5,
  parameter int TIMEOUT   = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 dut_reset,
  output logic [NUM_TESTS-1:0] test_req,
  input  logic [NUM_TESTS-1:0] test_busy,
  input  logic [NUM_TESTS-1:0] test_return,
  output logic [IDX_W-1:0]     cur_idx,
  output logic                 running,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_TESTS-1:0] pass_vec,
  output logic [NUM_TESTS-1:0] timeout_vec
);

  state_e                 state_q;
  logic                   dut_reset_q;
  logic [NUM_TESTS-1:0]   test_req_q;
  logic [IDX_W-1:0]       cur_idx_q;
  logic                   running_q;
  logic                   done_q;
  logic                   pass_q;
  logic [NUM_TESTS-1:0]   pass_vec_q;
  logic [NUM_TESTS-1:0]   timeout_vec_q;
  logic                   ret_q;
  logic                   tmo_q;

  logic                   rst_win_s;
  logic                   req_en_s;
  logic                   chk_en_s;
  logic                   tmo_s;
  logic [NUM_TESTS-1:0]   sel_s;
  logic                   busy_sel_s;
  logic                   ret_sel_s;
  logic                   pass_bit_s;
  logic                   stop_s;

  test_slot_timer #(
    .CNT_W    (CNT_W),
    .RST_START(RST_START),
    .RST_END  (RST_END),
    .REQ_DELAY(REQ_DELAY),
    .SETTLE   (SETTLE),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (state_q == PREP),
    .inc_i    (state_q == RUN),
    .rst_win_o(rst_win_s),
    .req_en_o (req_en_s),
    .chk_en_o (chk_en_s),
    .tmo_o    (tmo_s)
  );

  // Channel selection via a one-hot mask so the index never needs to match
  // the vector width; bits of other channels are masked off.
  always_comb begin
    sel_s      = NUM_TESTS'(1'b1) << cur_idx_q;
    busy_sel_s = |(test_busy & sel_s);
    ret_sel_s  = |(test_return & sel_s);
    pass_bit_s = ret_q & ~tmo_q;
`ifdef STOP_ON_FAIL_EN
    stop_s     = (cur_idx_q == IDX_W'(NUM_TESTS - 1)) || !pass_bit_s;
`else
    stop_s     = (cur_idx_q == IDX_W'(NUM_TESTS - 1));
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      dut_reset_q   <= 1'b0;
      test_req_q    <= '0;
      cur_idx_q     <= '0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      pass_vec_q    <= '0;
      timeout_vec_q <= '0;
      ret_q         <= 1'b0;
      tmo_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            pass_vec_q    <= '0;
            timeout_vec_q <= '0;
            cur_idx_q     <= '0;
            running_q     <= 1'b1;
            pass_q        <= 1'b0;
            state_q       <= PREP;
          end
        end
        PREP: begin
          // rst_win looks at the cleared counter the first RUN cycle will see.
          dut_reset_q <= rst_win_s;
          state_q     <= RUN;
        end
        RUN: begin
          // Completion is tested first so it wins over a same-cycle timeout.
          if (chk_en_s && !busy_sel_s) begin
            ret_q       <= ret_sel_s;
            tmo_q       <= 1'b0;
            test_req_q  <= '0;
            dut_reset_q <= 1'b0;
            state_q     <= CHECK;
          end else if (tmo_s) begin
            ret_q       <= 1'b0;
            tmo_q       <= 1'b1;
            test_req_q  <= '0;
            dut_reset_q <= 1'b0;
            state_q     <= CHECK;
          end else begin
            dut_reset_q <= rst_win_s;
            test_req_q  <= req_en_s ? sel_s : '0;
          end
        end
        CHECK: begin
          pass_vec_q    <= pass_vec_q | (pass_bit_s ? sel_s : '0);
          timeout_vec_q <= timeout_vec_q | (tmo_q ? sel_s : '0);
          if (stop_s) begin
            state_q <= DONE;
          end else begin
            cur_idx_q <= cur_idx_q + IDX_W'(1);
            state_q   <= PREP;
          end
        end
        DONE: begin
          // Tests never executed hold 0, so a stopped run reports pass=0.
          done_q    <= 1'b1;
          running_q <= 1'b0;
          pass_q    <= &pass_vec_q;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dut_reset   = dut_reset_q;
  assign test_req    = test_req_q;
  assign cur_idx     = cur_idx_q;
  assign running     = running_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign pass_vec    = pass_vec_q;
  assign timeout_vec = timeout_vec_q;

endmodule

// File: tb/tb_multi_test_runner.sv
// -----------------------------------------------------------------------------
// tb_multi_test_runner
// Directed bench for multi_test_runner with NUM_TESTS=2, TIMEOUT=200.
// Cycle t=0 is the PREP cycle of test 0 (first cycle with running high).
// A normal test (busy 2 cycles after req, for 20 cycles) spans PREP + 125 RUN
// cycles (counter 0..124) + CHECK = 127 cycles, so test 1 PREPs at t=127.
// -----------------------------------------------------------------------------
module tb_multi_test_runner;

  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          dut_reset;
  logic [NT-1:0] test_req;
  logic [NT-1:0] test_busy;
  logic [NT-1:0] test_return;
  logic [4:0]    cur_idx;
  logic          running;
  logic          done;
  logic          pass;
  logic [NT-1:0] pass_vec;
  logic [NT-1:0] timeout_vec;

  int checks   = 0;
  int failures = 0;

  // DUT behaviour model configuration
  int            age [NT];
  int            blen[NT];
  bit            stuck[NT];
  logic [NT-1:0] ret_cfg;

  // run statistics
  int         first_rst[NT];
  int         last_rst[NT];
  int         rst_cnt[NT];
  int         req_first[NT];
  bit         req_bad;
  int         done_t;
  int         done_cnt;
  logic       pass_d;
  logic [1:0] pv_d;
  logic [1:0] tv_d;
  logic [4:0] ci_d;
  logic       run_d;

  always #5 clk = ~clk;

  multi_test_runner #(
    .NUM_TESTS(NT),
    .CNT_W    (32),
    .RST_START(3),
    .RST_END  (8),
    .REQ_DELAY(100),
    .SETTLE   (5),
    .TIMEOUT  (200)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dut_reset  (dut_reset),
    .test_req   (test_req),
    .test_busy  (test_busy),
    .test_return(test_return),
    .cur_idx    (cur_idx),
    .running    (running),
    .done       (done),
    .pass       (pass),
    .pass_vec   (pass_vec),
    .timeout_vec(timeout_vec)
  );

  // Cycles since request was first seen, per channel.
  always @(posedge clk) begin
    for (int i = 0; i < NT; i++) age[i] <= test_req[i] ? age[i] + 1 : 0;
  end

  // Busy high for blen cycles starting 2 cycles after the request, or stuck.
  always_comb begin
    test_busy = '0;
    for (int i = 0; i < NT; i++)
      test_busy[i] = stuck[i] || ((age[i] >= 2) && (age[i] < 2 + blen[i]));
  end

  assign test_return = ret_cfg;

  task automatic cfg(input int l0, input int l1, input bit s0, input logic [1:0] r);
    blen[0] = l0; blen[1] = l1; stuck[0] = s0; stuck[1] = 1'b0; ret_cfg = r;
  endtask

  task automatic run_seq(input int budget, input int extra_t);
    int t;
    int ci;
    for (int i = 0; i < NT; i++) begin
      first_rst[i] = -1; last_rst[i] = -1; rst_cnt[i] = 0; req_first[i] = -1;
    end
    req_bad = 1'b0; done_t = -1; done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (t < budget) begin
      start = (t == extra_t) ? 1'b1 : 1'b0;
      ci = int'(cur_idx);
      if (dut_reset && ci < NT) begin
        if (first_rst[ci] < 0) first_rst[ci] = t;
        last_rst[ci] = t;
        rst_cnt[ci]++;
      end
      for (int c = 0; c < NT; c++)
        if (test_req[c] && req_first[c] < 0) req_first[c] = t;
      if (test_req != 2'b00 && (ci >= NT || test_req != (2'b01 << ci))) req_bad = 1'b1;
      if (done) begin
        done_cnt++;
        if (done_t < 0) begin
          done_t = t; pass_d = pass; pv_d = pass_vec; tv_d = timeout_vec;
          ci_d = cur_idx; run_d = running;
        end
      end
      if (done_t >= 0 && t >= done_t + 2) break;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    checks++;
    if (done_t < 0) begin
      failures++; $display("FAIL run_budget no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dut_reset, test_req, cur_idx, running, done, pass, pass_vec, timeout_vec} !== '0) begin
      failures++; $display("FAIL reset_outputs got %b exp 0",
        {dut_reset, test_req, cur_idx, running, done, pass, pass_vec, timeout_vec});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({running, done, test_req} !== '0) begin
      failures++; $display("FAIL reset_idle got %b exp 0", {running, done, test_req});
    end
  endtask

  task automatic test_all_pass(input int extra_t, input string nm);
    cfg(20, 20, 1'b0, 2'b11);
    run_seq(1000, extra_t);
    checks++; if (done_t !== 255) begin failures++; $display("FAIL %s done_t got %0d exp 255", nm, done_t); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL %s done_width got %0d exp 1", nm, done_cnt); end
    checks++; if (first_rst[0] !== 4 || last_rst[0] !== 9 || rst_cnt[0] !== 6) begin
      failures++; $display("FAIL %s rst0 got %0d..%0d n=%0d exp 4..9 n=6", nm, first_rst[0], last_rst[0], rst_cnt[0]); end
    checks++; if (first_rst[1] !== 131 || last_rst[1] !== 136 || rst_cnt[1] !== 6) begin
      failures++; $display("FAIL %s rst1 got %0d..%0d n=%0d exp 131..136 n=6", nm, first_rst[1], last_rst[1], rst_cnt[1]); end
    checks++; if (req_first[0] !== 103 || req_first[1] !== 230) begin
      failures++; $display("FAIL %s req_first got %0d,%0d exp 103,230", nm, req_first[0], req_first[1]); end
    checks++; if (req_bad !== 1'b0) begin failures++; $display("FAIL %s req_onehot got bad exp clean", nm); end
    checks++; if ({pass_d, pv_d, tv_d, run_d, ci_d} !== {1'b1, 2'b11, 2'b00, 1'b0, 5'd1}) begin
      failures++; $display("FAIL %s result got p=%b pv=%b tv=%b run=%b ci=%0d exp p=1 pv=11 tv=00 run=0 ci=1",
        nm, pass_d, pv_d, tv_d, run_d, ci_d); end
  endtask

  task automatic test_fail_last;
    cfg(20, 20, 1'b0, 2'b01);
    run_seq(1000, -1);
    checks++; if (done_t !== 255) begin failures++; $display("FAIL fail_last done_t got %0d exp 255", done_t); end
    checks++; if ({pass_d, pv_d, tv_d, ci_d} !== {1'b0, 2'b01, 2'b00, 5'd1}) begin
      failures++; $display("FAIL fail_last result got p=%b pv=%b tv=%b ci=%0d exp p=0 pv=01 tv=00 ci=1",
        pass_d, pv_d, tv_d, ci_d); end
  endtask

  task automatic test_timeout;
    cfg(20, 20, 1'b1, 2'b11);
    run_seq(1000, -1);
`ifdef STOP_ON_FAIL_EN
    checks++; if (done_t !== 205) begin failures++; $display("FAIL timeout done_t got %0d exp 205", done_t); end
    checks++; if ({pass_d, pv_d, tv_d, ci_d} !== {1'b0, 2'b00, 2'b01, 5'd0}) begin
      failures++; $display("FAIL timeout result got p=%b pv=%b tv=%b ci=%0d exp p=0 pv=00 tv=01 ci=0",
        pass_d, pv_d, tv_d, ci_d); end
`else
    // counter 201 at t=202 -> CHECK t=203 -> test 1 PREP t=204
    checks++; if (first_rst[1] !== 208 || req_first[1] !== 307) begin
      failures++; $display("FAIL timeout test1_timing got rst=%0d req=%0d exp rst=208 req=307", first_rst[1], req_first[1]); end
    checks++; if (done_t !== 332) begin failures++; $display("FAIL timeout done_t got %0d exp 332", done_t); end
    checks++; if ({pass_d, pv_d, tv_d, ci_d} !== {1'b0, 2'b10, 2'b01, 5'd1}) begin
      failures++; $display("FAIL timeout result got p=%b pv=%b tv=%b ci=%0d exp p=0 pv=10 tv=01 ci=1",
        pass_d, pv_d, tv_d, ci_d); end
`endif
  endtask

  task automatic test_tie;
    // busy high through counter 200, low at counter 201 where timeout also hits
    cfg(97, 20, 1'b0, 2'b11);
    run_seq(1000, -1);
    checks++; if (done_t !== 332) begin failures++; $display("FAIL tie done_t got %0d exp 332", done_t); end
    checks++; if ({pass_d, pv_d, tv_d} !== {1'b1, 2'b11, 2'b00}) begin
      failures++; $display("FAIL tie result got p=%b pv=%b tv=%b exp p=1 pv=11 tv=00", pass_d, pv_d, tv_d); end
  endtask

  task automatic test_reset_midrun;
    int seen;
    cfg(20, 20, 1'b0, 2'b11);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (235) @(negedge clk);
    checks++; if ({cur_idx, running, test_req, pass_vec} !== {5'd1, 1'b1, 2'b10, 2'b01}) begin
      failures++; $display("FAIL midrun_state got ci=%0d run=%b req=%b pv=%b exp ci=1 run=1 req=10 pv=01",
        cur_idx, running, test_req, pass_vec); end
    reset = 1'b1;
    #1;
    checks++;
    if ({dut_reset, test_req, cur_idx, running, done, pass, pass_vec, timeout_vec} !== '0) begin
      failures++; $display("FAIL midrun_async_reset got %b exp 0",
        {dut_reset, test_req, cur_idx, running, done, pass, pass_vec, timeout_vec});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done || running) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL midrun_no_done got %0d active cycles exp 0", seen); end
    test_all_pass(-1, "restart");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    cfg(20, 20, 1'b0, 2'b11);
    test_reset();
    test_all_pass(-1, "all_pass");
    test_fail_last();
    test_timeout();
    test_tie();
    test_reset_midrun();
    test_all_pass(50, "start_ignored");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
